// File: rtl/pipe_pkg.sv
// Shared types for the D->E pipeline boundary: sequencer state and
// the E-stage control bundle.
package pipe_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    typedef struct packed {
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       alusrc;
        logic       md;
        logic [3:0] aluop;
    } e_ctrl_t;

    // A bubble carries no side effects: no register write, no memory access.
    localparam e_ctrl_t E_CTRL_BUBBLE = '0;

    // Width of the mult/div occupancy counter (MD_LAT up to 15).
    localparam int MD_CNT_W = 4;

endpackage

// File: rtl/md_seq.sv
// Mult/div occupancy sequencer: keeps a mult/div resident in E for MD_LAT
// cycles and requests bubbles into E/M while it is busy.
module md_seq
    import pipe_pkg::*;
#(
    parameter int MD_LAT = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic capture,
    input  logic is_md,
    input  logic stall_ext,
    input  logic flush,
    output logic busy,
    output logic bubble
);

    // Busy cycles after the capture edge; the last occupancy cycle is spent in RUN.
    localparam logic [MD_CNT_W-1:0] CNT_LOAD = MD_CNT_W'(MD_LAT - 1);

    md_state_t             state;
    logic [MD_CNT_W-1:0]   cnt;

    // State/counter update: flush aborts, external stall freezes, capture of a mult/div arms.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else if (flush) begin
            state <= RUN;
            cnt   <= '0;
        end else if (state == MD_BUSY) begin
            if (!stall_ext) begin
                if (cnt == MD_CNT_W'(1)) begin
                    state <= RUN;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt - MD_CNT_W'(1);
                end
            end
        end else if (capture && is_md) begin
            state <= MD_BUSY;
            cnt   <= CNT_LOAD;
        end
    end

    assign busy   = (state == MD_BUSY);
    // While frozen by memory the E/M register is held too, so no bubble is pushed.
    assign bubble = busy & ~stall_ext;

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with the D->E stall/flush policy. Captures decoded
// operands and control from D, presents them to E (including the forwarding
// unit's rs/rt addresses), and delegates mult/div occupancy to md_seq.
module id_ex_pipe
    import pipe_pkg::*;
#(
    parameter int DW     = 32,
    parameter int MD_LAT = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_validD,
    input  logic [4:0]    i_addr_rsD,
    input  logic [4:0]    i_addr_rtD,
    input  logic [4:0]    i_addr_rdD,
    input  logic [DW-1:0] i_data_rsD,
    input  logic [DW-1:0] i_data_rtD,
    input  logic [DW-1:0] i_immD,
    input  logic          i_con_regwriteD,
    input  logic          i_con_memreadD,
    input  logic          i_con_memwriteD,
    input  logic          i_con_alusrcD,
    input  logic          i_con_mdD,
    input  logic [3:0]    i_con_aluopD,
    input  logic          i_stall_ext,
    input  logic          i_flush,
    output logic [4:0]    o_addr_rs,
    output logic [4:0]    o_addr_rt,
    output logic [4:0]    o_addr_rd,
    output logic [DW-1:0] o_data_rs,
    output logic [DW-1:0] o_data_rt,
    output logic [DW-1:0] o_imm,
    output logic          o_con_regwrite,
    output logic          o_con_memread,
    output logic          o_con_memwrite,
    output logic          o_con_alusrc,
    output logic          o_con_md,
    output logic [3:0]    o_con_aluop,
    output logic          o_valid,
    output logic          o_stallF,
    output logic          o_stallD,
    output logic          o_bubbleM,
    output logic          o_md_busy
);

    logic    md_busy;
    logic    md_bubble;
    logic    hold;
    logic    capture;
    e_ctrl_t ctrl_d;
    e_ctrl_t ctrl_q;
    logic    valid_q;
    logic [4:0]    rs_q, rt_q, rd_q;
    logic [DW-1:0] data_rs_q, data_rt_q, imm_q;

    assign hold    = i_stall_ext | md_busy;
    // Flush takes precedence over any hold reason.
    assign capture = ~i_flush & ~hold;

    assign ctrl_d = '{
        regwrite: i_con_regwriteD,
        memread:  i_con_memreadD,
        memwrite: i_con_memwriteD,
        alusrc:   i_con_alusrcD,
        md:       i_con_mdD,
        aluop:    i_con_aluopD
    };

    md_seq #(
        .MD_LAT (MD_LAT)
    ) u_md_seq (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .capture   (capture),
        .is_md     (i_validD & i_con_mdD),
        .stall_ext (i_stall_ext),
        .flush     (i_flush),
        .busy      (md_busy),
        .bubble    (md_bubble)
    );

    // E-stage register bank: flush loads a bubble, hold keeps, otherwise capture D.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q   <= 1'b0;
            ctrl_q    <= E_CTRL_BUBBLE;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            data_rs_q <= '0;
            data_rt_q <= '0;
            imm_q     <= '0;
        end else if (i_flush || (capture && !i_validD)) begin
            valid_q   <= 1'b0;
            ctrl_q    <= E_CTRL_BUBBLE;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            data_rs_q <= '0;
            data_rt_q <= '0;
            imm_q     <= '0;
        end else if (capture) begin
            valid_q   <= 1'b1;
            ctrl_q    <= ctrl_d;
            rs_q      <= i_addr_rsD;
            rt_q      <= i_addr_rtD;
            rd_q      <= i_addr_rdD;
            data_rs_q <= i_data_rsD;
            data_rt_q <= i_data_rtD;
            imm_q     <= i_immD;
        end
    end

    assign o_valid        = valid_q;
    assign o_addr_rs      = rs_q;
    assign o_addr_rt      = rt_q;
    assign o_addr_rd      = rd_q;
    assign o_data_rs      = data_rs_q;
    assign o_data_rt      = data_rt_q;
    assign o_imm          = imm_q;
    assign o_con_regwrite = ctrl_q.regwrite;
    assign o_con_memread  = ctrl_q.memread;
    assign o_con_memwrite = ctrl_q.memwrite;
    assign o_con_alusrc   = ctrl_q.alusrc;
    assign o_con_md       = ctrl_q.md;
    assign o_con_aluop    = ctrl_q.aluop;

    // A flushed D instruction is gone, so F/D must be free to refetch.
    assign o_stallF  = hold & ~i_flush;
    assign o_stallD  = hold & ~i_flush;
    assign o_bubbleM = md_bubble;
    assign o_md_busy = md_busy;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: stimulus pushes expected per-cycle
// responses from a behavioural model, a monitor pops and compares.
module tb_id_ex_pipe;

    localparam int DW     = 32;
    localparam int MD_LAT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          validD;
    logic [4:0]    rsD, rtD, rdD;
    logic [DW-1:0] drsD, drtD, immD;
    logic          rwD, mrD, mwD, asD, mdD;
    logic [3:0]    aluopD;
    logic          stall_ext, flush;

    logic [4:0]    o_rs, o_rt, o_rd;
    logic [DW-1:0] o_drs, o_drt, o_imm;
    logic          o_rw, o_mr, o_mw, o_as, o_md;
    logic [3:0]    o_aluop;
    logic          o_valid, o_stallF, o_stallD, o_bubbleM, o_md_busy;

    always #5 clk = ~clk;

    id_ex_pipe #(.DW(DW), .MD_LAT(MD_LAT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_validD(validD),
        .i_addr_rsD(rsD), .i_addr_rtD(rtD), .i_addr_rdD(rdD),
        .i_data_rsD(drsD), .i_data_rtD(drtD), .i_immD(immD),
        .i_con_regwriteD(rwD), .i_con_memreadD(mrD), .i_con_memwriteD(mwD),
        .i_con_alusrcD(asD), .i_con_mdD(mdD), .i_con_aluopD(aluopD),
        .i_stall_ext(stall_ext), .i_flush(flush),
        .o_addr_rs(o_rs), .o_addr_rt(o_rt), .o_addr_rd(o_rd),
        .o_data_rs(o_drs), .o_data_rt(o_drt), .o_imm(o_imm),
        .o_con_regwrite(o_rw), .o_con_memread(o_mr), .o_con_memwrite(o_mw),
        .o_con_alusrc(o_as), .o_con_md(o_md), .o_con_aluop(o_aluop),
        .o_valid(o_valid), .o_stallF(o_stallF), .o_stallD(o_stallD),
        .o_bubbleM(o_bubbleM), .o_md_busy(o_md_busy)
    );

    // An instruction as seen in one stage (valid=0 means empty slot).
    typedef struct packed {
        logic          valid;
        logic [4:0]    rs, rt, rd;
        logic [DW-1:0] drs, drt, imm;
        logic          rw, mr, mw, as_, md;
        logic [3:0]    aluop;
    } instr_t;

    typedef struct {
        logic   stall;
        logic   bubm;
        logic   busy;
        instr_t e;
    } exp_t;

    exp_t   sb[$];
    int     n_cmp = 0;
    int     n_bad = 0;

    // Reference model: what sits in E, and how many more cycles it must stay
    // busy because it is a multi-cycle mult/div.
    instr_t m_e;
    int     m_left;

    function automatic instr_t dut_e();
        instr_t r;
        r.valid = o_valid; r.rs = o_rs; r.rt = o_rt; r.rd = o_rd;
        r.drs = o_drs; r.drt = o_drt; r.imm = o_imm;
        r.rw = o_rw; r.mr = o_mr; r.mw = o_mw; r.as_ = o_as; r.md = o_md;
        r.aluop = o_aluop;
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic instr_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] rd, input logic rw, input logic mr,
                                  input logic mw, input logic md, input logic [3:0] op);
        instr_t r;
        r.valid = v; r.rs = rs; r.rt = rt; r.rd = rd;
        r.drs = $urandom; r.drt = $urandom; r.imm = $urandom;
        r.rw = rw; r.mr = mr; r.mw = mw; r.as_ = 1'($urandom); r.md = md; r.aluop = op;
        return r;
    endfunction

    function automatic instr_t rnd();
        instr_t r;
        r = mk(($urandom_range(0, 99) < 85), 5'($urandom), 5'($urandom), 5'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 99) < 20),
               4'($urandom));
        return r;
    endfunction

    task automatic apply(input instr_t d, input logic st, input logic fl);
        validD = d.valid; rsD = d.rs; rtD = d.rt; rdD = d.rd;
        drsD = d.drs; drtD = d.drt; immD = d.imm;
        rwD = d.rw; mrD = d.mr; mwD = d.mw; asD = d.as_; mdD = d.md; aluopD = d.aluop;
        stall_ext = st; flush = fl;
    endtask

    // One D-stage cycle: drive inputs, predict this cycle's stall/bubble
    // signals and the E contents after the next edge.
    task automatic drive(input instr_t d, input logic st, input logic fl);
        exp_t x;
        logic held;
        @(negedge clk);
        apply(d, st, fl);
        held   = st || (m_left > 0);
        x.stall = held && !fl;
        x.bubm  = (m_left > 0) && !st;
        x.busy  = (m_left > 0);
        if (fl) begin
            m_e = '0; m_left = 0;
        end else if (held) begin
            if (!st && m_left > 0) m_left--;
        end else begin
            m_e    = d.valid ? d : '0;
            m_left = (d.valid && d.md) ? MD_LAT - 1 : 0;
        end
        x.e = m_e;
        sb.push_back(x);
    endtask

    // Asynchronous reset pulse away from any clock edge; outputs must clear at once.
    task automatic async_reset();
        @(negedge clk);
        apply('0, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_e", 128'(dut_e()), 128'(0));
        check("async_rst_busy", 128'({o_md_busy, o_bubbleM, o_stallF, o_stallD}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        m_e = '0; m_left = 0;
    endtask

    // Monitor: pops one expectation per cycle while the scoreboard holds one.
    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() != 0) begin
                x = sb.pop_front();
                check("stallF",  128'(o_stallF),  128'(x.stall));
                check("stallD",  128'(o_stallD),  128'(x.stall));
                check("bubbleM", 128'(o_bubbleM), 128'(x.bubm));
                check("md_busy", 128'(o_md_busy), 128'(x.busy));
                @(posedge clk);
                #1;
                check("e_regs", 128'(dut_e()), 128'(x.e));
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        instr_t add, sw, mul, mul2, add2;
        apply('0, 1'b0, 1'b0);
        m_e = '0; m_left = 0;

        // Reset held with random D inputs: everything reads zero.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            apply(rnd(), 1'b0, 1'($urandom));
            #2;
            check("reset_e", 128'(dut_e()), 128'(0));
            check("reset_stall", 128'({o_stallF, o_stallD, o_bubbleM, o_md_busy}), 128'(0));
        end
        @(negedge clk);
        apply('0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // add rs=3 rt=4 rd=5, then an external stall with changing D inputs.
        add = mk(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
        drive(add, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(rnd(), 1'b1, 1'b0);

        // Flush with a valid sw in D, then flush together with an external stall.
        sw = mk(1'b1, 5'd8, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2);
        drive(sw, 1'b0, 1'b1);
        drive(add, 1'b0, 1'b0);
        drive(sw, 1'b1, 1'b1);

        // mult followed by add, no stall: add reaches E on the 5th cycle.
        mul  = mk(1'b1, 5'd10, 5'd11, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9);
        add2 = mk(1'b1, 5'd12, 5'd13, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
        drive(mul, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(add2, 1'b0, 1'b0);

        // mult with two external stall cycles mid-busy.
        drive(mul, 1'b0, 1'b0);
        drive(add2, 1'b0, 1'b0);
        drive(add2, 1'b1, 1'b0);
        drive(add2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(add2, 1'b0, 1'b0);

        // Flush while busy.
        drive(mul, 1'b0, 1'b0);
        drive(add2, 1'b0, 1'b0);
        drive(add2, 1'b0, 1'b1);
        drive(add2, 1'b0, 1'b0);

        // Back-to-back mults.
        mul2 = mk(1'b1, 5'd20, 5'd21, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd10);
        drive(mul, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(mul2, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(add2, 1'b0, 1'b0);
        drive(add, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a busy period.
        drive(mul, 1'b0, 1'b0);
        drive(add2, 1'b0, 1'b0);
        async_reset();
        drive(add, 1'b0, 1'b0);

        // Randomized traffic with occasional stalls, flushes and resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) async_reset();
            drive(rnd(), ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 7));
        end

        for (int i = 0; i < 6 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        #4;
        check("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
